// File: rtl/debsched_pkg.sv
// Shared types for the multi-channel debounce scheduler: scan state, event record, FIFO depth.
package debsched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

    // Channel field is sized for the largest supported channel count; tops use the low bits.
    localparam int EVT_CH_W = 8;

    typedef struct packed {
        logic [EVT_CH_W-1:0] ch;
        logic                rise;
    } evt_t;

    localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/debsched_evt_fifo.sv
// Event FIFO with a registered head stage; the head register counts toward FIFO_DEPTH entries.
module debsched_evt_fifo
    import debsched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  evt_t data_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output evt_t data_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    evt_t          mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q, occ;
    evt_t          head_q;
    logic          head_vld_q;
    logic          move;

    // Entries always pass through the memory first, which gives the extra cycle of latency.
    assign move    = (cnt_q != '0) && (!head_vld_q || pop_i);
    assign occ     = cnt_q + {{AW{1'b0}}, head_vld_q};
    assign full_o  = (occ == (AW+1)'(FIFO_DEPTH));
    assign empty_o = !head_vld_q;
    assign data_o  = head_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            if (push_i) begin
                wr_q <= wr_q + 1'b1;
            end
            if (move) begin
                head_q <= mem_q[rd_q];
                rd_q   <= rd_q + 1'b1;
            end
            head_vld_q <= move ? 1'b1 : (pop_i ? 1'b0 : head_vld_q);
            cnt_q      <= cnt_q + (AW+1)'(push_i) - (AW+1)'(move);
        end
    end

endmodule

// File: rtl/debounce_scheduler.sv
// Time-shared multi-channel debouncer with a valid/ready event port.
// Define DEBSCHED_EVT_FIFO_EN to buffer events in a 4-entry FIFO instead of a single register.
module debounce_scheduler
    import debsched_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 8,
    parameter int STABLE_CNT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         in_i,
    output logic [N_CH-1:0]         out_o,
    output logic                    evt_valid_o,
    input  logic                    evt_ready_i,
    output logic [$clog2(N_CH)-1:0] evt_ch_o,
    output logic                    evt_rise_o,
    output logic                    evt_ovf_o,
    input  logic                    ovf_clr_i
);

    localparam int CH_W = $clog2(N_CH);
    localparam int PW   = $clog2(TICK_DIV);
    localparam int CW   = $clog2(STABLE_CNT + 1);

    if (TICK_DIV < N_CH + 1) begin : g_bad_div
        $error("TICK_DIV must be >= N_CH+1");
    end
    if (STABLE_CNT < 1) begin : g_bad_stable
        $error("STABLE_CNT must be >= 1");
    end
    if (N_CH < 2 || CH_W >= EVT_CH_W) begin : g_bad_nch
        $error("N_CH out of supported range");
    end

    logic [N_CH-1:0]          sync1_q, sync2_q;
    logic [PW-1:0]            pre_q, pre_d;
    logic                     tick;
    scan_state_e              state_q, state_d;
    logic [CH_W-1:0]          idx_q, idx_d;
    logic [N_CH-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]          out_q, out_d;
    logic                     new_evt;
    evt_t                     new_evt_data;
    logic                     xfer, drop;
    logic                     ovf_q, ovf_d;
    logic                     evt_unused;

    assign tick  = (pre_q == PW'(TICK_DIV - 1));
    assign pre_d = tick ? '0 : pre_q + 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (idx_q == CH_W'(N_CH - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One channel per scan cycle, so at most one event can be produced per cycle.
    always_comb begin
        cnt_d        = cnt_q;
        out_d        = out_q;
        new_evt      = 1'b0;
        new_evt_data = '0;
        if (state_q == SCAN) begin
            if (sync2_q[idx_q] == out_q[idx_q]) begin
                cnt_d[idx_q] = '0;
            end else if (cnt_q[idx_q] + CW'(1) == CW'(STABLE_CNT)) begin
                out_d[idx_q]      = ~out_q[idx_q];
                cnt_d[idx_q]      = '0;
                new_evt           = 1'b1;
                new_evt_data.ch   = EVT_CH_W'(idx_q);
                new_evt_data.rise = ~out_q[idx_q];
            end else begin
                cnt_d[idx_q] = cnt_q[idx_q] + CW'(1);
            end
        end
    end

    assign xfer = evt_valid_o & evt_ready_i;

`ifdef DEBSCHED_EVT_FIFO_EN
    logic fifo_full, fifo_empty;
    evt_t fifo_head;

    assign drop = new_evt & fifo_full & ~xfer;

    debsched_evt_fifo u_evt_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (new_evt & ~drop),
        .data_i  (new_evt_data),
        .pop_i   (xfer),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_o  (fifo_head)
    );

    assign evt_valid_o = ~fifo_empty;
    assign evt_ch_o    = fifo_head.ch[CH_W-1:0];
    assign evt_rise_o  = fifo_head.rise;
    assign evt_unused  = ^fifo_head.ch[EVT_CH_W-1:CH_W];
`else
    logic evt_vld_q, evt_vld_d;
    evt_t evt_q, evt_d;

    // A transfer in the same cycle frees the register for the new event.
    always_comb begin
        evt_vld_d = evt_vld_q;
        evt_d     = evt_q;
        drop      = 1'b0;
        if (new_evt) begin
            if (!evt_vld_q || xfer) begin
                evt_vld_d = 1'b1;
                evt_d     = new_evt_data;
            end else begin
                drop = 1'b1;
            end
        end else if (xfer) begin
            evt_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_vld_q <= 1'b0;
            evt_q     <= '0;
        end else begin
            evt_vld_q <= evt_vld_d;
            evt_q     <= evt_d;
        end
    end

    assign evt_valid_o = evt_vld_q;
    assign evt_ch_o    = evt_q.ch[CH_W-1:0];
    assign evt_rise_o  = evt_q.rise;
    assign evt_unused  = ^evt_q.ch[EVT_CH_W-1:CH_W];
`endif

    assign ovf_d = drop ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            pre_q   <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
            pre_q   <= pre_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_o     = out_q;
    assign evt_ovf_o = ovf_q;

endmodule
